// File: rtl/button_debouncer_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer_channel
// Description : One button channel. Polarity normalisation, two-flop
//               synchronizer, stability counter, debounced level and
//               one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer_channel #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int COUNTER_WIDTH   = 17,
    parameter bit ACTIVE_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_level,
    output logic o_pressed,
    output logic o_released
);

    // A raw level of ACTIVE_LEVEL maps to 1 (pressed) after normalisation.
    localparam logic                     c_invert = ~ACTIVE_LEVEL;
    localparam logic [COUNTER_WIDTH-1:0] c_last   = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_one    = COUNTER_WIDTH'(1);

    // Declaration values match the reset values so reset may be tied low.
    logic                     r_sync1    = 1'b0;
    logic                     r_sync2    = 1'b0;
    logic                     r_stable   = 1'b0;
    logic                     r_pressed  = 1'b0;
    logic                     r_released = 1'b0;
    logic [COUNTER_WIDTH-1:0] r_count    = '0;
    logic                     w_level;

    assign w_level = i_button ^ c_invert;

    // Bring the normalised button level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_level;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable   <= 1'b0;
            r_count    <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_count <= '0;
            end else if (r_count == c_last) begin
                r_stable   <= r_sync2;
                r_count    <= '0;
                r_pressed  <= r_sync2;
                r_released <= ~r_sync2;
            end else begin
                r_count <= r_count + c_one;
            end
        end
    end

    assign o_level    = r_stable;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Board-level push-button conditioner. NUM_INPUTS independent
//               channels, each synchronized and debounced, giving clean
//               active-high levels plus press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int CLOCK_FREQUENCY  = 12000000,
    parameter int DEBOUNCE_TIME_US = 10000,
    parameter int NUM_INPUTS       = 2,
    parameter int ACTIVE_LEVEL     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] button_in,
    output logic [NUM_INPUTS-1:0] button_out,
    output logic [NUM_INPUTS-1:0] button_pressed,
    output logic [NUM_INPUTS-1:0] button_released
);

    // A zero-length debounce window degenerates to a one-cycle filter.
    localparam int DEBOUNCE_RAW    = (CLOCK_FREQUENCY / 1000000) * DEBOUNCE_TIME_US;
    localparam int DEBOUNCE_CYCLES = (DEBOUNCE_RAW == 0) ? 1 : DEBOUNCE_RAW;
    localparam int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam bit c_active_high   = (ACTIVE_LEVEL != 0);

    // One fully independent debouncer per button.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_channel
            button_debouncer_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .COUNTER_WIDTH   (COUNTER_WIDTH),
                .ACTIVE_LEVEL    (c_active_high)
            ) u_channel (
                .clk        (clock),
                .rst        (reset),
                .i_button   (button_in[gi]),
                .o_level    (button_out[gi]),
                .o_pressed  (button_pressed[gi]),
                .o_released (button_released[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench. Two instances (active-high and
//               active-low buttons), a window-based reference model checked
//               every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_a = 2'b11;
    logic [1:0] btn_b = 2'b11;
    logic [1:0] out_a, pr_a, rl_a;
    logic [1:0] out_b, pr_b, rl_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    button_debouncer #(
        .CLOCK_FREQUENCY (1000000),
        .DEBOUNCE_TIME_US(4),
        .NUM_INPUTS      (2),
        .ACTIVE_LEVEL    (1)
    ) u_dut_a (
        .clock          (clock),
        .reset          (reset),
        .button_in      (btn_a),
        .button_out     (out_a),
        .button_pressed (pr_a),
        .button_released(rl_a)
    );

    button_debouncer #(
        .CLOCK_FREQUENCY (1000000),
        .DEBOUNCE_TIME_US(4),
        .NUM_INPUTS      (2),
        .ACTIVE_LEVEL    (0)
    ) u_dut_b (
        .clock          (clock),
        .reset          (reset),
        .button_in      (btn_b),
        .button_out     (out_b),
        .button_pressed (pr_b),
        .button_released(rl_b)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the "seen" level is the pressed-level input two edges
    // old; the output flips only when the last D seen samples all disagree
    // with it.
    bit [1:0] m_hist [2][3];
    bit [1:0] m_win  [2][D];
    bit [1:0] m_out  [2];
    bit [1:0] m_pr   [2];
    bit [1:0] m_rl   [2];

    task automatic model_step(input int d, input logic rst_now, input logic [1:0] cond);
        bit [1:0] seen;
        bit       all_diff;
        if (rst_now) begin
            for (int i = 0; i < 3; i++) m_hist[d][i] = 2'b00;
            for (int i = 0; i < D; i++) m_win[d][i] = 2'b00;
            m_out[d] = 2'b00;
            m_pr[d]  = 2'b00;
            m_rl[d]  = 2'b00;
            return;
        end
        m_hist[d][2] = m_hist[d][1];
        m_hist[d][1] = m_hist[d][0];
        m_hist[d][0] = cond;
        seen = m_hist[d][2];
        for (int i = D - 1; i > 0; i--) m_win[d][i] = m_win[d][i-1];
        m_win[d][0] = seen;
        m_pr[d] = 2'b00;
        m_rl[d] = 2'b00;
        for (int c = 0; c < 2; c++) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++)
                if (m_win[d][i][c] == m_out[d][c]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_out[d][c]) m_rl[d][c] = 1'b1;
                else             m_pr[d][c] = 1'b1;
                m_out[d][c] = ~m_out[d][c];
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clock) begin
        model_step(0, reset, btn_a);
        model_step(1, reset, ~btn_b);
        #1;
        check("cyc_out_a", out_a, m_out[0]);
        check("cyc_pr_a",  pr_a,  m_pr[0]);
        check("cyc_rl_a",  rl_a,  m_rl[0]);
        check("cyc_out_b", out_b, m_out[1]);
        check("cyc_pr_b",  pr_b,  m_pr[1]);
        check("cyc_rl_b",  rl_b,  m_rl[1]);
        check("cyc_both_a", pr_a & rl_a, 2'b00);
    end

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held with both buttons pressed.
        repeat (3) @(posedge clock);
        #2;
        check("rst_out_a", out_a, 2'b00);
        check("rst_pr_a",  pr_a,  2'b00);
        check("rst_rl_a",  rl_a,  2'b00);
        check("rst_out_b", out_b, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("rst_e5_out_a", out_a, 2'b00);
        @(posedge clock);
        #2;
        check("rst_e6_out_a", out_a, 2'b11);
        check("rst_e6_pr_a",  pr_a,  2'b11);
        @(posedge clock);
        #2;
        check("rst_e7_pr_a",  pr_a,  2'b00);
        check("rst_e7_out_a", out_a, 2'b11);

        // Release everything and settle.
        @(negedge clock);
        btn_a = 2'b00;
        repeat (10) @(posedge clock);
        #2;
        check("idle_out_a", out_a, 2'b00);

        // Clean press on ch0 of both instances (B is active-low).
        @(negedge clock);
        btn_a = 2'b01;
        btn_b = 2'b10;
        repeat (5) @(posedge clock);
        #2;
        check("press_e5_out_a", out_a, 2'b00);
        check("press_e5_out_b", out_b, 2'b00);
        @(posedge clock);
        #2;
        check("press_e6_out_a", out_a, 2'b01);
        check("press_e6_pr_a",  pr_a,  2'b01);
        check("press_e6_out_b", out_b, 2'b01);
        check("press_e6_pr_b",  pr_b,  2'b01);
        @(posedge clock);
        #2;
        check("press_e7_pr_a", pr_a, 2'b00);
        repeat (4) @(posedge clock);

        // Clean release on ch0.
        @(negedge clock);
        btn_a = 2'b00;
        repeat (5) @(posedge clock);
        #2;
        check("rel_e5_out_a", out_a, 2'b01);
        @(posedge clock);
        #2;
        check("rel_e6_out_a", out_a, 2'b00);
        check("rel_e6_rl_a",  rl_a,  2'b01);
        @(posedge clock);
        #2;
        check("rel_e7_rl_a", rl_a, 2'b00);
        repeat (4) @(posedge clock);

        // Bounce on ch0: 2-cycle holds, then a final settle high.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            btn_a[0] = pat[i];
            repeat (2) @(negedge clock);
        end
        btn_a[0] = 1'b1;
        repeat (5) @(posedge clock);
        #2;
        check("bounce_e5_out_a", out_a, 2'b00);
        @(posedge clock);
        #2;
        check("bounce_e6_out_a", out_a, 2'b01);
        check("bounce_e6_pr_a",  pr_a,  2'b01);
        @(negedge clock);
        btn_a = 2'b00;
        repeat (12) @(posedge clock);

        // Three-cycle glitch on ch1 is rejected.
        @(negedge clock);
        btn_a = 2'b10;
        repeat (3) @(negedge clock);
        btn_a = 2'b00;
        repeat (10) @(posedge clock);
        #2;
        check("glitch_out_a", out_a, 2'b00);

        // Reset part-way through a press count.
        @(negedge clock);
        btn_a = 2'b01;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("midrst_out_a", out_a, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("midrst_e5_out_a", out_a, 2'b00);
        @(posedge clock);
        #2;
        check("midrst_e6_out_a", out_a, 2'b01);
        check("midrst_e6_pr_a",  pr_a,  2'b01);

        repeat (3) @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
